// File: rtl/ac_sequencer.sv
// ac_sequencer: codec bring-up and run-time control.
// On start, writes CFG_NUM table words to the codec over an I2C master.
// Each word gets up to MAX_RETRY attempts. After the last word the block
// waits SETTLE_CYCLES, then enables the audio serial interface and serves
// run-time volume writes. All outputs come straight from flops.
module ac_sequencer #(
    parameter int         CFG_NUM       = 10,
    parameter logic [6:0] DEV_ADDR      = 7'h1A,
    parameter int         SETTLE_CYCLES = 1024,
    parameter int         MAX_RETRY     = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic [$clog2(CFG_NUM)-1:0] cfgIdx,
    input  logic [15:0]                cfgWord,
    output logic                       i2cReq,
    output logic [6:0]                 i2cAddr,
    output logic [15:0]                i2cData,
    input  logic                       i2cDone,
    input  logic                       i2cErr,
    output logic                       cmdModEn,
    input  logic                       volReq,
    input  logic [15:0]                volWord,
    output logic                       volAck,
    output logic                       busy,
    output logic                       error
);

    localparam int IDX_W    = $clog2(CFG_NUM);
    localparam int RETRY_W  = $clog2(MAX_RETRY + 1);
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(CFG_NUM - 1);
    localparam logic [RETRY_W-1:0]  LAST_RETRY  = RETRY_W'(MAX_RETRY - 1);
    localparam logic [SETTLE_W-1:0] LAST_SETTLE = SETTLE_W'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        SETTLE,
        RUN,
        VOL,
        ERR
    } seqState_e;

    seqState_e            state, stateNext;
    logic [IDX_W-1:0]     idxNext;
    logic [RETRY_W-1:0]   retryCnt, retryNext;
    logic [SETTLE_W-1:0]  settleCnt, settleNext;
    logic                 startPend, pendNext;
    logic                 reqNext, modEnNext, volAckNext, busyNext, errorNext;
    logic [15:0]          dataNext;

    assign i2cAddr = DEV_ADDR;

    // Next-state and next-output logic for the whole sequencer.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        stateNext  = state;
        idxNext    = cfgIdx;
        retryNext  = retryCnt;
        settleNext = settleCnt;
        pendNext   = startPend;
        reqNext    = i2cReq;
        dataNext   = i2cData;
        modEnNext  = cmdModEn;
        volAckNext = 1'b0;
        errorNext  = error;

        unique case (state)
            IDLE, ERR: begin
                if (start) begin
                    stateNext = FETCH;
                    idxNext   = '0;
                    retryNext = '0;
                    errorNext = 1'b0;
                end
            end

            FETCH: begin
                dataNext  = cfgWord;
                reqNext   = 1'b1;
                stateNext = WAIT;
            end

            WAIT: begin
                // A cycle with both done and err asserted counts as a failure.
                if (i2cErr) begin
                    reqNext   = 1'b0;
                    retryNext = retryCnt + RETRY_W'(1);
                    if (retryCnt == LAST_RETRY) begin
                        stateNext = ERR;
                        errorNext = 1'b1;
                        modEnNext = 1'b0;
                    end else begin
                        stateNext = FETCH;
                    end
                end else if (i2cDone) begin
                    reqNext = 1'b0;
                    if (cfgIdx == LAST_IDX) begin
                        stateNext  = SETTLE;
                        settleNext = '0;
                    end else begin
                        stateNext = FETCH;
                        idxNext   = cfgIdx + IDX_W'(1);
                        retryNext = '0;
                    end
                end
            end

            SETTLE: begin
                if (settleCnt == LAST_SETTLE) begin
                    stateNext = RUN;
                    modEnNext = 1'b1;
                end else begin
                    settleNext = settleCnt + SETTLE_W'(1);
                end
            end

            RUN: begin
                // Reconfiguration has priority over a simultaneous volume request.
                if (start) begin
                    stateNext = FETCH;
                    idxNext   = '0;
                    retryNext = '0;
                    errorNext = 1'b0;
                    modEnNext = 1'b0;
                end else if (volReq) begin
                    dataNext  = volWord;
                    reqNext   = 1'b1;
                    stateNext = VOL;
                end
            end

            VOL: begin
                // A start here disables the audio interface at once but waits
                // for the in-flight volume write before reconfiguring.
                if (start) begin
                    pendNext  = 1'b1;
                    modEnNext = 1'b0;
                end
                if (i2cDone || i2cErr) begin
                    reqNext    = 1'b0;
                    volAckNext = 1'b1;
                    if (i2cErr) begin
                        errorNext = 1'b1;
                    end
                    if (start || startPend) begin
                        stateNext = FETCH;
                        pendNext  = 1'b0;
                        idxNext   = '0;
                        retryNext = '0;
                        errorNext = 1'b0;
                        modEnNext = 1'b0;
                    end else begin
                        stateNext = RUN;
                    end
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase

        busyNext = !(stateNext inside {IDLE, RUN, ERR});
    end

    // State, counters and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cfgIdx    <= '0;
            retryCnt  <= '0;
            settleCnt <= '0;
            startPend <= 1'b0;
            i2cReq    <= 1'b0;
            i2cData   <= '0;
            cmdModEn  <= 1'b0;
            volAck    <= 1'b0;
            busy      <= 1'b0;
            error     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state     <= stateNext;
            cfgIdx    <= idxNext;
            retryCnt  <= retryNext;
            settleCnt <= settleNext;
            startPend <= pendNext;
            i2cReq    <= reqNext;
            i2cData   <= dataNext;
            cmdModEn  <= modEnNext;
            volAck    <= volAckNext;
            busy      <= busyNext;
            error     <= errorNext;
        end
    end

endmodule

// File: doc/ac_sequencer.md
AC_SEQUENCER -- requirements
Module: ac_sequencer

Interface
REQ-001 Parameter CFG_NUM, default 10: number of codec configuration words written at bring-up (2..64).
REQ-002 Parameter DEV_ADDR, default 7'h1A: 7-bit I2C device address of the codec.
REQ-003 Parameter SETTLE_CYCLES, default 1024: clk cycles to wait between the last config write and enabling the audio interface (>=1).
REQ-004 Parameter MAX_RETRY, default 3: attempts per word before declaring an error (>=1).
REQ-005 clk  in  1  single system clock; all logic on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  one-cycle pulse requesting full (re)configuration.
REQ-008 cfgIdx  out  $clog2(CFG_NUM)  index into the external configuration table.
REQ-009 cfgWord  in  16  table word for cfgIdx, valid combinationally in the same cycle: [15:9] register address, [8:0] register data.
REQ-010 i2cReq  out  1  write request to the I2C master.
REQ-011 i2cAddr  out  7  device address; constant DEV_ADDR.
REQ-012 i2cData  out  16  word to write; stable while i2cReq=1.
REQ-013 i2cDone  in  1  one-cycle pulse: write acknowledged by the codec.
REQ-014 i2cErr  in  1  one-cycle pulse: write failed (NACK or bus error).
REQ-015 cmdModEn  out  1  enable for the audio serial interface.
REQ-016 volReq  in  1  level request for a run-time volume write.
REQ-017 volWord  in  16  volume word, same format as cfgWord.
REQ-018 volAck  out  1  one-cycle pulse: volume write finished, with or without error.
REQ-019 busy  out  1  high in every state except IDLE, RUN and ERR.
REQ-020 error  out  1  sticky failure flag.

Function
REQ-021 States: IDLE, FETCH, WAIT, SETTLE, RUN, VOL, ERR; all outputs are registered.
REQ-022 Start: start=1 in IDLE or ERR moves to FETCH on the next edge, with cfgIdx=0, retry count 0 and error cleared.
REQ-023 FETCH lasts one cycle: i2cData<=cfgWord, i2cReq<=1, then WAIT.
REQ-024 WAIT: i2cReq and i2cData hold; i2cReq drops on the edge where i2cDone or i2cErr is sampled.
REQ-025 If i2cDone and i2cErr are both high in the same cycle, the cycle is treated as an error.
REQ-026 i2cDone with cfgIdx<CFG_NUM-1: cfgIdx++, retry count reset, go to FETCH.
REQ-027 i2cDone with cfgIdx=CFG_NUM-1: go to SETTLE with the settle counter cleared.
REQ-028 i2cErr: retry count++; if the count is below MAX_RETRY, go to FETCH with the same cfgIdx.
REQ-029 i2cErr when the count reaches MAX_RETRY: go to ERR with error=1 and cmdModEn=0.
REQ-030 SETTLE counts exactly SETTLE_CYCLES cycles, then enters RUN; cmdModEn=1 from the first RUN cycle.
REQ-031 RUN with volReq=1: i2cData<=volWord, i2cReq<=1, go to VOL; cmdModEn stays 1.
REQ-032 VOL: hold the request; on i2cDone or i2cErr, pulse volAck for one cycle and return to RUN.
REQ-033 i2cErr in VOL sets error=1 with no retry; the sequencer remains operational.
REQ-034 start in RUN or VOL: cmdModEn<=0 on the next edge and a full reconfiguration begins.
REQ-035 start in VOL is deferred until i2cDone or i2cErr; volAck is still pulsed, then FETCH.
REQ-036 start in FETCH, WAIT or SETTLE is ignored.
REQ-037 volReq outside RUN is ignored; it is served once RUN is reached if still high.
REQ-038 start and volReq together in RUN: start wins and volAck is not pulsed.

Reset
REQ-039 reset=1 immediately forces IDLE, cfgIdx=0, i2cReq=0, i2cData=0, cmdModEn=0, volAck=0, busy=0, error=0, and clears the counters, including in the middle of a transfer.
REQ-040 After reset release, the sequencer stays in IDLE until start.

Verification
REQ-041 CFG_NUM=4, SETTLE_CYCLES=8, each request acked by i2cDone after 5 cycles -> cfgIdx steps 0..3, i2cData equals the table words in order, cmdModEn=1 exactly 8 cycles after the 4th i2cDone.
REQ-042 i2cErr twice on word 2, then i2cDone -> word 2 is issued 3 times and completion is normal, error=0; three i2cErr on one word -> ERR, error=1, cmdModEn=0, busy=0.
REQ-043 In RUN, volReq with volWord=16'h0579 -> i2cData=16'h0579, cmdModEn stays 1 throughout, one volAck pulse after i2cDone.
REQ-044 i2cDone and i2cErr asserted in the same cycle on word 0 -> word 0 is retried and the retry count increments.
REQ-045 reset pulse asserted during WAIT -> i2cReq=0 and cmdModEn=0 immediately; a subsequent start restarts from cfgIdx=0.
REQ-046 start in RUN -> cmdModEn=0 on the next cycle and the full sequence repeats; start during SETTLE -> no effect.
